// File: rtl/board_io_conditioner.sv
// Board I/O conditioner: button synchronise/debounce with press/release
// pulses, power-on and long-press software reset sequencing for the core,
// and a global-brightness PWM stage for the LED outputs.
//
// dbg_state_o exposes the reset FSM state:
//   0 = POR, 1 = RUN, 2 = SWRST, 3 = WAIT_REL.
module board_io_conditioner #(
  parameter int                N_BTN          = 4,
  parameter logic [N_BTN-1:0]  BTN_ACTIVE_LOW = 4'b0001,
  parameter int                DEB_CYCLES     = 16,
  parameter int                POR_CYCLES     = 8,
  parameter int                RST_BTN        = 0,
  parameter int                LONG_CYCLES    = 64,
  parameter int                N_LED          = 8,
  parameter int                PWM_BITS       = 4
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic [N_BTN-1:0]    btn_raw,
  output logic [N_BTN-1:0]    btn_level,
  output logic [N_BTN-1:0]    btn_press,
  output logic [N_BTN-1:0]    btn_release,
  output logic                core_rst_n,
  input  logic [N_LED-1:0]    led_in,
  input  logic [PWM_BITS-1:0] led_duty,
  output logic [N_LED-1:0]    led_out,
  output logic [1:0]          dbg_state_o
);

  // Debounce counter is wide enough to hold DEB_CYCLES-1, the terminal count.
  localparam int             DW       = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0]  DEB_LAST = DW'(DEB_CYCLES - 1);

  // One shared FSM counter covers both the reset pulse and the hold timer.
  localparam int             CMAX     = (LONG_CYCLES > POR_CYCLES) ? LONG_CYCLES : POR_CYCLES;
  localparam int             CW       = $clog2(CMAX + 1);
  localparam logic [CW-1:0]  POR_LAST  = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0]  LONG_LAST = CW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_POR      = 2'd0,
    ST_RUN      = 2'd1,
    ST_SWRST    = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Button path
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0]          sync1_q, sync2_q;
  logic [N_BTN-1:0]          btn_norm;
  logic [N_BTN-1:0][DW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [N_BTN-1:0]          level_q, level_d;
  logic [N_BTN-1:0]          press_q, press_d;
  logic [N_BTN-1:0]          release_q, release_d;

  // Two-flop synchronizer; reset value is the idle (not pressed) pin level.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= BTN_ACTIVE_LOW;
      sync2_q <= BTN_ACTIVE_LOW;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // After normalisation a 1 always means pressed, whatever the pin polarity.
  assign btn_norm = sync2_q ^ BTN_ACTIVE_LOW;

  // Debounce: count consecutive mismatching cycles; any matching cycle restarts.
  always_comb begin
    deb_cnt_d = '0;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (btn_norm[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          level_d[i]   = btn_norm[i];
          press_d[i]   = btn_norm[i];
          release_d[i] = ~btn_norm[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state and edge pulses; pulses coincide with the first new level cycle.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

  // ---------------------------------------------------------------------------
  // Reset sequencer
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rst_btn_level;
  logic            core_en;
  logic            core_rst_n_q;

  assign rst_btn_level = level_q[RST_BTN];

  // Next-state: POR and SWRST time the reset pulse, RUN times the hold,
  // WAIT_REL blocks a repeat reset until the button is let go.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_POR: begin
        if (cnt_q == POR_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (rst_btn_level) begin
          if (cnt_q == LONG_LAST) begin
            state_d = ST_SWRST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_SWRST: begin
        if (cnt_q == POR_LAST) begin
          state_d = ST_WAIT_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_REL: begin
        cnt_d = '0;
        if (!rst_btn_level) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_POR;
        cnt_d   = '0;
      end
    endcase
  end

  // The core is released only in RUN and WAIT_REL; the output register adds one cycle.
  assign core_en = (state_q == ST_RUN) || (state_q == ST_WAIT_REL);

  // FSM state, counter and registered core reset.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_POR;
      cnt_q        <= '0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_rst_n_q <= core_en;
    end
  end

  assign core_rst_n  = core_rst_n_q;
  assign dbg_state_o = state_q;

  // ---------------------------------------------------------------------------
  // LED PWM
  // ---------------------------------------------------------------------------
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_on;
  logic [N_LED-1:0]    led_d;
  logic [N_LED-1:0]    led_q;

  // A new duty is taken only as the counter wraps, so a period is never split.
  always_comb begin
    duty_d = duty_q;
    if (pwm_cnt_q == {PWM_BITS{1'b1}}) begin
      duty_d = led_duty;
    end
  end

  assign pwm_on = (pwm_cnt_q < duty_q);

  // LED drive is gated by the same enable that feeds core_rst_n, keeping both in step.
  always_comb begin
    led_d = '0;
    if (core_en && pwm_on) begin
      led_d = led_in;
    end
  end

  // Free-running PWM counter, latched duty and registered LED outputs.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      led_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      duty_q    <= duty_d;
      led_q     <= led_d;
    end
  end

  assign led_out = led_q;

endmodule

// File: tb/tb_board_io_conditioner.sv
// Bench for board_io_conditioner: directed button, long-press, reset and PWM
// stimulus; expected output events are queued with their cycle numbers and
// a negedge monitor pops and compares as the DUT produces them.
module tb_board_io_conditioner;

  localparam int N_BTN    = 4;
  localparam int N_LED    = 8;
  localparam int PWM_BITS = 4;
  localparam int W        = 40;

  localparam logic [3:0] K_PRESS = 4'd1;
  localparam logic [3:0] K_REL   = 4'd2;
  localparam logic [3:0] K_CFALL = 4'd3;
  localparam logic [3:0] K_CRISE = 4'd4;

  // ---------------------------------------------------------------- clock/reset
  logic                CLK = 1'b0;
  logic                rst_n;
  logic [N_BTN-1:0]    btn_raw;
  logic [N_BTN-1:0]    btn_level, btn_press, btn_release;
  logic                core_rst_n;
  logic [N_LED-1:0]    led_in;
  logic [PWM_BITS-1:0] led_duty;
  logic [N_LED-1:0]    led_out;
  logic [1:0]          dbg_state;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic         core_prev = 1'b0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  board_io_conditioner dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .core_rst_n (core_rst_n),
    .led_in     (led_in),
    .led_duty   (led_duty),
    .led_out    (led_out),
    .dbg_state_o(dbg_state)
  );

  // ---------------------------------------------------------------- helpers
  function automatic logic [W-1:0] ev(input int unsigned c, input logic [3:0] k, input logic [3:0] ch);
    return {c[31:0], k, ch};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // ---------------------------------------------------------------- scoreboard
  task automatic got_event(input logic [W-1:0] got);
    logic [W-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event_unexpected: got cyc=%0d kind=%0d ch=%0d, none expected",
               got[39:8], got[7:4], got[3:0]);
    end else begin
      e = exp_q.pop_front();
      if (e !== got) begin
        n_fail++;
        $display("FAIL event: got cyc=%0d kind=%0d ch=%0d expected cyc=%0d kind=%0d ch=%0d",
                 got[39:8], got[7:4], got[3:0], e[39:8], e[7:4], e[3:0]);
      end
    end
  endtask

  // Monitor: every output event is matched against the head of the queue.
  always @(negedge CLK) begin
    if (core_rst_n !== core_prev) begin
      got_event(ev(cyc, (core_rst_n === 1'b1) ? K_CRISE : K_CFALL, 4'd0));
    end
    core_prev <= core_rst_n;
    for (int i = 0; i < N_BTN; i++) begin
      if (btn_press[i] === 1'b1) begin
        got_event(ev(cyc, K_PRESS, 4'(i)));
        check("press_level", {31'd0, btn_level[i]}, 32'd1);
        check("press_not_release", {31'd0, btn_release[i]}, 32'd0);
      end
      if (btn_release[i] === 1'b1) begin
        got_event(ev(cyc, K_REL, 4'(i)));
        check("release_level", {31'd0, btn_level[i]}, 32'd0);
      end
    end
    if (core_rst_n === 1'b0) begin
      check("led_off_in_reset", {24'd0, led_out}, 32'd0);
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic led_window(output int on, output int bad);
    on  = 0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (led_out === led_in) on++;
      else if (led_out !== '0) bad++;
      @(negedge CLK);
    end
  endtask

  task automatic finish_report();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int unsigned c;
    int on, bad, k;

    rst_n    = 1'b0;
    btn_raw  = 4'b0001;
    led_in   = 8'hFF;
    led_duty = 4'd15;
    tick(3);

    check("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    check("rst_led_out", {24'd0, led_out}, 32'd0);
    check("rst_btn_level", {28'd0, btn_level}, 32'd0);
    check("rst_btn_press", {28'd0, btn_press}, 32'd0);
    check("rst_btn_release", {28'd0, btn_release}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    // Power-on: core_rst_n rises on the 9th edge after release.
    exp_q.push_back(ev(cyc + 9, K_CRISE, 4'd0));
    rst_n = 1'b1;
    tick(5);
    check("por_state", {30'd0, dbg_state}, 32'd0);
    tick(15);
    check("run_state", {30'd0, dbg_state}, 32'd1);

    // Two active-high channels pressed together, with a 10-cycle glitch on ch1.
    c = cyc;
    exp_q.push_back(ev(c + 18, K_PRESS, 4'd1));
    exp_q.push_back(ev(c + 18, K_PRESS, 4'd3));
    btn_raw[1] = 1'b1;
    btn_raw[3] = 1'b1;
    tick(30);
    btn_raw[1] = 1'b0;
    tick(10);
    btn_raw[1] = 1'b1;
    tick(30);
    check("level_after_glitch", {28'd0, btn_level}, 32'h0000000A);

    c = cyc;
    exp_q.push_back(ev(c + 18, K_REL, 4'd1));
    exp_q.push_back(ev(c + 18, K_REL, 4'd3));
    btn_raw[1] = 1'b0;
    btn_raw[3] = 1'b0;
    tick(30);
    check("level_released", {28'd0, btn_level}, 32'd0);

    // Debounce boundary on ch2: 15 cycles ignored, 16 cycles accepted.
    btn_raw[2] = 1'b1;
    tick(15);
    btn_raw[2] = 1'b0;
    tick(30);
    check("level_15_ignored", {28'd0, btn_level}, 32'd0);
    c = cyc;
    exp_q.push_back(ev(c + 18, K_PRESS, 4'd2));
    exp_q.push_back(ev(c + 34, K_REL, 4'd2));
    btn_raw[2] = 1'b1;
    tick(16);
    btn_raw[2] = 1'b0;
    tick(40);

    // PWM: 4 of 16 cycles on.
    led_in   = 8'hA5;
    led_duty = 4'd4;
    tick(40);
    led_window(on, bad);
    check("led_duty4_on", 32'(on), 32'd4);
    check("led_duty4_pattern", 32'(bad), 32'd0);

    // Duty change mid-period takes effect only from the next period.
    k = 0;
    while (led_out !== '0 && k < 40) begin @(negedge CLK); k++; end
    k = 0;
    while (led_out === '0 && k < 40) begin @(negedge CLK); k++; end
    check("led_sync_found", {31'd0, k < 40}, 32'd1);
    tick(2);
    led_duty = 4'd8;
    tick(14);
    led_window(on, bad);
    check("led_duty8_on", 32'(on), 32'd8);
    check("led_duty8_pattern", 32'(bad), 32'd0);

    led_duty = 4'd0;
    tick(40);
    led_window(on, bad);
    check("led_duty0_on", 32'(on), 32'd0);
    check("led_duty0_pattern", 32'(bad), 32'd0);

    led_duty = 4'd15;
    tick(40);
    led_window(on, bad);
    check("led_duty15_on", 32'(on), 32'd15);
    check("led_duty15_pattern", 32'(bad), 32'd0);

    // Long press on active-low ch0: one 8-cycle reset per hold.
    led_in = 8'hFF;
    c = cyc;
    exp_q.push_back(ev(c + 18, K_PRESS, 4'd0));
    exp_q.push_back(ev(c + 83, K_CFALL, 4'd0));
    exp_q.push_back(ev(c + 91, K_CRISE, 4'd0));
    exp_q.push_back(ev(c + 218, K_REL, 4'd0));
    btn_raw[0] = 1'b0;
    tick(85);
    check("swrst_state", {30'd0, dbg_state}, 32'd2);
    tick(65);
    check("wait_rel_state", {30'd0, dbg_state}, 32'd3);
    tick(50);
    btn_raw[0] = 1'b1;
    tick(40);
    check("run_after_release", {30'd0, dbg_state}, 32'd1);

    // Second hold, then rst_n asserted while in SWRST.
    c = cyc;
    exp_q.push_back(ev(c + 18, K_PRESS, 4'd0));
    exp_q.push_back(ev(c + 83, K_CFALL, 4'd0));
    btn_raw[0] = 1'b0;
    tick(86);
    check("swrst_state_2", {30'd0, dbg_state}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    check("mid_rst_led_out", {24'd0, led_out}, 32'd0);
    check("mid_rst_btn_level", {28'd0, btn_level}, 32'd0);
    check("mid_rst_btn_press", {28'd0, btn_press}, 32'd0);
    check("mid_rst_btn_release", {28'd0, btn_release}, 32'd0);
    check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    btn_raw[0] = 1'b1;
    tick(3);
    exp_q.push_back(ev(cyc + 9, K_CRISE, 4'd0));
    rst_n = 1'b1;
    tick(5);
    check("por_again_state", {30'd0, dbg_state}, 32'd0);
    tick(25);
    check("run_again_state", {30'd0, dbg_state}, 32'd1);

    check("queue_drained", exp_q.size(), 32'd0);
    finish_report();
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    finish_report();
    $fatal(1, "watchdog");
  end

endmodule
